// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates ROB tags, collects ALU/LSB writebacks, commits one entry per
// cycle in program order and raises a registered flush on branch mispredict or jalr.
module reorder_buffer #(
  parameter int unsigned ROB_SZ     = 16,
  parameter int unsigned ROB_SZ_LOG = 4,
  parameter int unsigned REG_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic [31:0]             issue_pc,
  input  logic                    issue_pred,
  output logic [ROB_SZ_LOG:0]     issue_tag,
  output logic                    rob_full,
  input  logic [ROB_SZ_LOG:0]     q_tag_j,
  input  logic [ROB_SZ_LOG:0]     q_tag_k,
  output logic                    q_rdy_j,
  output logic                    q_rdy_k,
  output logic [31:0]             q_val_j,
  output logic [31:0]             q_val_k,
  input  logic                    alu_valid,
  input  logic [ROB_SZ_LOG:0]     alu_tag,
  input  logic [31:0]             alu_res,
  input  logic                    alu_taken,
  input  logic [31:0]             alu_target,
  input  logic                    lad_valid,
  input  logic [ROB_SZ_LOG:0]     lad_tag,
  input  logic [31:0]             lad_res,
  output logic                    commit_valid,
  output logic [REG_W-1:0]        commit_rd,
  output logic [31:0]             commit_res,
  output logic [ROB_SZ_LOG:0]     commit_tag,
  output logic                    commit_store,
  output logic                    flush,
  output logic [31:0]             flush_pc
);

  localparam int unsigned TAG_W = ROB_SZ_LOG + 1;
  localparam logic [1:0] T_REG  = 2'd0;
  localparam logic [1:0] T_BR   = 2'd1;
  localparam logic [1:0] T_ST   = 2'd2;
  localparam logic [1:0] T_JALR = 2'd3;

  typedef struct packed {
    logic [1:0]       typ;
    logic [REG_W-1:0] rd;
    logic [31:0]      pc;
    logic             pred;
    logic [31:0]      val;
    logic             taken;
    logic [31:0]      target;
  } entry_t;

  entry_t              rob [ROB_SZ];
  logic [ROB_SZ-1:0]   busy;
  logic [ROB_SZ-1:0]   ready;
  logic [TAG_W-1:0]    head;
  logic [TAG_W-1:0]    tail;
  logic [TAG_W-1:0]    count;

  logic [ROB_SZ_LOG-1:0] head_idx;
  logic [ROB_SZ_LOG-1:0] tail_idx;
  logic [ROB_SZ_LOG-1:0] alu_idx;
  logic [ROB_SZ_LOG-1:0] lad_idx;
  entry_t                head_e;
  logic                  wb_en;
  logic                  alu_hit;
  logic                  lad_hit;
  logic                  commit_go;
  logic                  mispred;
  logic                  flush_go;
  logic                  issue_acc;

  // Tags are 1-based; tag 0 and tags beyond ROB_SZ never name an entry.
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(ROB_SZ));
  endfunction

  function automatic logic [ROB_SZ_LOG-1:0] idx(input logic [TAG_W-1:0] t);
    return ROB_SZ_LOG'(t - TAG_W'(1));
  endfunction

  function automatic logic [TAG_W-1:0] incr(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(ROB_SZ)) ? TAG_W'(1) : p + TAG_W'(1);
  endfunction

  assign issue_tag = tail;
  assign rob_full  = (count == TAG_W'(ROB_SZ));

  // Edge decisions, all from pre-edge state.
  always_comb begin
    head_idx  = idx(head);
    tail_idx  = idx(tail);
    alu_idx   = idx(alu_tag);
    lad_idx   = idx(lad_tag);
    head_e    = rob[head_idx];
    wb_en     = rdy && !flush;
    alu_hit   = wb_en && alu_valid && tag_ok(alu_tag) && busy[alu_idx];
    lad_hit   = wb_en && lad_valid && tag_ok(lad_tag) && busy[lad_idx];
    commit_go = rdy && busy[head_idx] && ready[head_idx];
    mispred   = (head_e.typ == T_BR) && (head_e.taken != head_e.pred);
    flush_go  = commit_go && (mispred || (head_e.typ == T_JALR));
    issue_acc = rdy && issue_valid && !rob_full && !flush && !flush_go;
  end

  // Pointer, occupancy and per-entry status bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= TAG_W'(1);
      tail  <= TAG_W'(1);
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (flush_go) begin
      head  <= TAG_W'(1);
      tail  <= TAG_W'(1);
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else begin
      if (lad_hit) ready[lad_idx] <= 1'b1;
      if (alu_hit) ready[alu_idx] <= 1'b1;
      if (issue_acc) begin
        busy[tail_idx]  <= 1'b1;
        ready[tail_idx] <= 1'b0;
        tail            <= incr(tail);
      end
      if (commit_go) begin
        busy[head_idx]  <= 1'b0;
        ready[head_idx] <= 1'b0;
        head            <= incr(head);
      end
      count <= count + TAG_W'(issue_acc) - TAG_W'(commit_go);
    end
  end

  // Payload storage; meaningful only while the matching busy bit is set. ALU written last so it wins.
  always_ff @(posedge clk) begin
    if (issue_acc) begin
      rob[tail_idx].typ  <= issue_type;
      rob[tail_idx].rd   <= issue_rd;
      rob[tail_idx].pc   <= issue_pc;
      rob[tail_idx].pred <= issue_pred;
    end
    if (lad_hit) rob[lad_idx].val <= lad_res;
    if (alu_hit) begin
      rob[alu_idx].val    <= alu_res;
      rob[alu_idx].taken  <= alu_taken;
      rob[alu_idx].target <= alu_target;
    end
  end

  // Registered retirement and redirect outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_res   <= '0;
      commit_tag   <= '0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      flush        <= 1'b0;
      if (commit_go) begin
        commit_tag   <= head;
        commit_rd    <= head_e.rd;
        commit_res   <= head_e.val;
        commit_valid <= ((head_e.typ == T_REG) || (head_e.typ == T_JALR)) && (head_e.rd != '0);
        commit_store <= (head_e.typ == T_ST);
        if (flush_go) begin
          flush    <= 1'b1;
          flush_pc <= ((head_e.typ == T_JALR) || head_e.taken) ? head_e.target : head_e.pc + 32'd4;
        end
      end
    end
  end

  // Operand lookup: stored ready value first, then same-cycle writeback bypass.
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t);
    logic [ROB_SZ_LOG-1:0] i;
    i = idx(t);
    if (t == '0) return {1'b1, 32'd0};
    if (tag_ok(t) && busy[i] && ready[i]) return {1'b1, rob[i].val};
    if (!flush && alu_valid && (alu_tag == t)) return {1'b1, alu_res};
    if (!flush && lad_valid && (lad_tag == t)) return {1'b1, lad_res};
    return {1'b0, 32'd0};
  endfunction

  always_comb begin
    {q_rdy_j, q_val_j} = lookup(q_tag_j);
    {q_rdy_k, q_val_k} = lookup(q_tag_k);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: commit scoreboard, table-driven operand queries and
// hand-written sequences for wrap, full, flush, rdy stall and async reset.
module tb_reorder_buffer;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic        issue_pred;
  logic [4:0]  issue_tag;
  logic        rob_full;
  logic [4:0]  q_tag_j, q_tag_k;
  logic        q_rdy_j, q_rdy_k;
  logic [31:0] q_val_j, q_val_k;
  logic        alu_valid;
  logic [4:0]  alu_tag;
  logic [31:0] alu_res;
  logic        alu_taken;
  logic [31:0] alu_target;
  logic        lad_valid;
  logic [4:0]  lad_tag;
  logic [31:0] lad_res;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_res;
  logic [4:0]  commit_tag;
  logic        commit_store;
  logic        flush;
  logic [31:0] flush_pc;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  tag;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [4:0]  qtag;
    logic        av;
    logic [4:0]  at;
    logic [31:0] ar;
    logic        lv;
    logic [4:0]  lt;
    logic [31:0] lr;
    logic        er;
    logic [31:0] ev;
  } qvec_t;
  qvec_t qv[8];

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred(issue_pred), .issue_tag(issue_tag), .rob_full(rob_full),
    .q_tag_j(q_tag_j), .q_tag_k(q_tag_k), .q_rdy_j(q_rdy_j), .q_rdy_k(q_rdy_k),
    .q_val_j(q_val_j), .q_val_k(q_val_k),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_res(alu_res), .alu_taken(alu_taken),
    .alu_target(alu_target),
    .lad_valid(lad_valid), .lad_tag(lad_tag), .lad_res(lad_res),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_res(commit_res),
    .commit_tag(commit_tag), .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    lad_valid   = 1'b0;
  endtask

  task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic pred);
    issue_valid = 1'b1;
    issue_type  = t;
    issue_rd    = rd;
    issue_pc    = pc;
    issue_pred  = pred;
  endtask

  task automatic alu_wb(input logic [4:0] tag, input logic [31:0] res, input logic taken,
                        input logic [31:0] target);
    alu_valid  = 1'b1;
    alu_tag    = tag;
    alu_res    = res;
    alu_taken  = taken;
    alu_target = target;
  endtask

  task automatic lad_wb(input logic [4:0] tag, input logic [31:0] res);
    lad_valid = 1'b1;
    lad_tag   = tag;
    lad_res   = res;
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic [31:0] res, input logic [4:0] tag);
    sb_t e;
    e.rd  = rd;
    e.res = res;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Register-write retirements are matched in order against the scoreboard.
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (!rst && commit_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: commit tag %0d rd %0d, expected none", commit_tag, commit_rd);
      end else begin
        e = sb.pop_front();
        check("sb_rd",  32'(commit_rd),  32'(e.rd));
        check("sb_res", commit_res,      e.res);
        check("sb_tag", 32'(commit_tag), 32'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    issue_valid = 1'b0; issue_type = 2'd0; issue_rd = '0; issue_pc = '0; issue_pred = 1'b0;
    q_tag_j = '0; q_tag_k = '0;
    alu_valid = 1'b0; alu_tag = '0; alu_res = '0; alu_taken = 1'b0; alu_target = '0;
    lad_valid = 1'b0; lad_tag = '0; lad_res = '0;

    // Query vectors evaluated with tags 4,6,7 busy/not-ready and tag 5 ready holding 0x55.
    qv[0] = '{5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 32'h0};
    qv[1] = '{5'd5, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 32'h55};
    qv[2] = '{5'd4, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
    qv[3] = '{5'd4, 1'b1, 5'd4, 32'h2A, 1'b0, 5'd0, 32'h0,  1'b1, 32'h2A};
    qv[4] = '{5'd6, 1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 32'h66, 1'b1, 32'h66};
    qv[5] = '{5'd6, 1'b1, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22, 1'b1, 32'h11};
    qv[6] = '{5'd7, 1'b1, 5'd6, 32'h11, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
    qv[7] = '{5'd5, 1'b1, 5'd5, 32'h99, 1'b0, 5'd0, 32'h0,  1'b1, 32'h55};

    #2;
    check("reset_issue_tag",    32'(issue_tag),    32'd1);
    check("reset_rob_full",     32'(rob_full),     32'd0);
    check("reset_commit_valid", 32'(commit_valid), 32'd0);
    check("reset_flush",        32'(flush),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three reg-writes, out-of-order writeback, in-order commit.
    for (int i = 1; i <= 3; i++) begin
      check("issue_tag_seq", 32'(issue_tag), 32'(i));
      set_issue(2'd0, 5'(i), 32'(i * 4), 1'b0);
      tick();
    end
    idle();
    expect_commit(5'd1, 32'd7, 5'd1);
    expect_commit(5'd2, 32'd5, 5'd2);
    expect_commit(5'd3, 32'h33, 5'd3);
    check("after3_issue_tag", 32'(issue_tag), 32'd4);
    check("after3_rob_full",  32'(rob_full),  32'd0);
    alu_wb(5'd2, 32'd5, 1'b0, 32'd0);
    tick();
    check("wb2_no_commit", 32'(commit_valid), 32'd0);
    alu_wb(5'd1, 32'd7, 1'b0, 32'd0);
    tick();
    check("wb1_not_yet", 32'(commit_valid), 32'd0);
    idle();
    tick();
    check("commit1", 32'(commit_valid), 32'd1);
    lad_wb(5'd3, 32'h33);
    tick();
    check("commit2", 32'(commit_valid), 32'd1);
    idle();
    tick();
    check("commit3", 32'(commit_valid), 32'd1);
    tick();
    check("drained", 32'(commit_valid), 32'd0);

    // Tags 4..7: rd 8,5,6,0; tag5 made ready before the query table.
    set_issue(2'd0, 5'd8, 32'h10, 1'b0); expect_commit(5'd8, 32'h44, 5'd4); tick();
    set_issue(2'd0, 5'd5, 32'h14, 1'b0); expect_commit(5'd5, 32'h55, 5'd5); tick();
    set_issue(2'd0, 5'd6, 32'h18, 1'b0); expect_commit(5'd6, 32'h11, 5'd6); tick();
    set_issue(2'd0, 5'd0, 32'h1C, 1'b0); tick();
    idle();
    alu_wb(5'd5, 32'h55, 1'b0, 32'd0);
    tick();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q_tag_j = qv[i].qtag;
      q_tag_k = qv[i].qtag;
      alu_valid = qv[i].av; alu_tag = qv[i].at; alu_res = qv[i].ar;
      lad_valid = qv[i].lv; lad_tag = qv[i].lt; lad_res = qv[i].lr;
      #1;
      check($sformatf("query%0d_rdy_j", i), 32'(q_rdy_j), 32'(qv[i].er));
      check($sformatf("query%0d_rdy_k", i), 32'(q_rdy_k), 32'(qv[i].er));
      if (qv[i].er) check($sformatf("query%0d_val_j", i), q_val_j, qv[i].ev);
      if (qv[i].er) check($sformatf("query%0d_val_k", i), q_val_k, qv[i].ev);
    end
    idle();
    rdy = 1'b1;
    #1;

    // Dual writeback on distinct tags, then same tag (ALU wins), then four in-order commits.
    alu_wb(5'd6, 32'h11, 1'b0, 32'd0);
    lad_wb(5'd7, 32'h77);
    tick();
    check("dual_wb_no_commit", 32'(commit_valid), 32'd0);
    alu_wb(5'd4, 32'h44, 1'b0, 32'd0);
    lad_wb(5'd4, 32'h99);
    tick();
    idle();
    check("same_tag_no_commit", 32'(commit_valid), 32'd0);
    tick(); check("commit_tag4", 32'(commit_valid), 32'd1);
    tick(); check("commit_tag5", 32'(commit_valid), 32'd1);
    tick(); check("commit_tag6", 32'(commit_valid), 32'd1);
    tick(); check("rd0_suppressed", 32'(commit_valid), 32'd0);
    check("empty_issue_tag", 32'(issue_tag), 32'd8);

    // Fill all 16 entries starting at tag 8, crossing the 16 -> 1 wrap.
    for (int i = 0; i < 16; i++) begin
      check("fill_issue_tag", 32'(issue_tag), 32'(((7 + i) % 16) + 1));
      set_issue(2'd0, 5'd1, 32'(i * 4), 1'b0);
      if (i == 0) expect_commit(5'd1, 32'h800, 5'd8);
      tick();
    end
    check("full_flag", 32'(rob_full),  32'd1);
    check("full_tag",  32'(issue_tag), 32'd8);
    alu_wb(5'd8, 32'h800, 1'b0, 32'd0);
    tick();
    check("drop_while_full_tag",  32'(issue_tag), 32'd8);
    check("drop_while_full_flag", 32'(rob_full),  32'd1);
    alu_valid = 1'b0;
    tick();
    check("commit_with_drop_cv",   32'(commit_valid), 32'd1);
    check("commit_with_drop_full", 32'(rob_full),     32'd0);
    check("commit_with_drop_tag",  32'(issue_tag),    32'd8);
    set_issue(2'd0, 5'd2, 32'h300, 1'b0);
    tick();
    idle();
    check("refill_full", 32'(rob_full),  32'd1);
    check("refill_tag",  32'(issue_tag), 32'd9);

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_commit_tag", 32'(commit_tag), 32'd0);
    check("async_rst_commit_rd",  32'(commit_rd),  32'd0);
    check("async_rst_commit_res", commit_res,      32'd0);
    check("async_rst_full",       32'(rob_full),   32'd0);
    check("async_rst_issue_tag",  32'(issue_tag),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Store, correctly predicted branch, rdy stall, then jalr.
    set_issue(2'd2, 5'd0, 32'h70, 1'b0); tick();
    set_issue(2'd1, 5'd0, 32'h80, 1'b1); tick();
    set_issue(2'd3, 5'd9, 32'h90, 1'b0); expect_commit(5'd9, 32'h94, 5'd3); tick();
    idle();
    lad_wb(5'd1, 32'hDEAD);
    alu_wb(5'd2, 32'd0, 1'b1, 32'h500);
    tick();
    check("st_wb_no_store", 32'(commit_store), 32'd0);
    lad_valid = 1'b0;
    alu_wb(5'd3, 32'h94, 1'b1, 32'h300);
    tick();
    alu_valid = 1'b0;
    check("store_commit",    32'(commit_store), 32'd1);
    check("store_no_cv",     32'(commit_valid), 32'd0);
    check("store_no_flush",  32'(flush),        32'd0);
    tick();
    check("br_ok_no_flush",  32'(flush),        32'd0);
    check("br_ok_no_store",  32'(commit_store), 32'd0);
    rdy = 1'b0;
    set_issue(2'd0, 5'd4, 32'hA0, 1'b0);
    tick();
    check("stall_no_flush", 32'(flush),        32'd0);
    check("stall_no_cv",    32'(commit_valid), 32'd0);
    check("stall_tag",      32'(issue_tag),    32'd4);
    rdy = 1'b1;
    idle();
    tick();
    check("jalr_flush",     32'(flush),        32'd1);
    check("jalr_flush_pc",  flush_pc,          32'h300);
    check("jalr_cv",        32'(commit_valid), 32'd1);
    check("jalr_tag_reset", 32'(issue_tag),    32'd1);
    set_issue(2'd0, 5'd4, 32'hB0, 1'b0);
    alu_wb(5'd1, 32'h1, 1'b0, 32'd0);
    tick();
    idle();
    check("flush_one_cycle",     32'(flush),     32'd0);
    check("issue_ignored_flush", 32'(issue_tag), 32'd1);

    // Taken mispredict; issue on the decision edge is dropped.
    set_issue(2'd1, 5'd0, 32'h40, 1'b0); tick();
    idle();
    alu_wb(5'd1, 32'd0, 1'b1, 32'h100);
    tick();
    idle();
    set_issue(2'd0, 5'd5, 32'h44, 1'b0);
    tick();
    idle();
    check("mp_taken_flush",    32'(flush),     32'd1);
    check("mp_taken_flush_pc", flush_pc,       32'h100);
    check("mp_taken_tag",      32'(issue_tag), 32'd1);
    tick();
    check("mp_taken_pulse",    32'(flush),     32'd0);

    // Not-taken mispredict redirects to pc+4.
    set_issue(2'd1, 5'd0, 32'h200, 1'b1); tick();
    idle();
    alu_wb(5'd1, 32'd0, 1'b0, 32'h999);
    tick();
    idle();
    tick();
    check("mp_nt_flush",    32'(flush), 32'd1);
    check("mp_nt_flush_pc", flush_pc,   32'h204);
    tick();
    check("mp_nt_pulse",    32'(flush), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
